// File: rtl/wb_arbiter.sv
// Two-lane writeback arbiter: the ALU lane and the immediate lane share one register-file write port through a single output register.
// Define WB_ARB_RR_EN for round-robin contention; the default build gives the ALU lane fixed priority.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [15:0] alu_data,
    input  logic [3:0]  alu_rd,
    output logic        alu_ready,
    input  logic        imm_valid,
    input  logic [11:0] imm_data,
    input  logic [3:0]  imm_rd,
    output logic        imm_ready,
    input  logic        wb_ready,
    output logic        wb_en,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        mux_sel,
    output logic [15:0] wb_count
);

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_IMM = 1'b1;

`ifdef WB_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    logic last_grant;
    logic load;
    logic contend_imm;
    logic grant_alu;
    logic grant_imm;

    // Contention goes to IMM only in round-robin mode when ALU won last time.
    always_comb begin
        load        = !wb_en || wb_ready;
        contend_imm = RR_EN && (last_grant == GRANT_ALU);
        grant_alu   = rst_n && load && alu_valid && !(imm_valid && contend_imm);
        grant_imm   = rst_n && load && imm_valid && !(alu_valid && !contend_imm);
    end

    assign alu_ready = grant_alu;
    assign imm_ready = grant_imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en      <= 1'b0;
            wb_rd      <= 4'd0;
            wb_data    <= 16'd0;
            mux_sel    <= GRANT_ALU;
            last_grant <= GRANT_IMM;
        end else if (load) begin
            wb_en <= grant_alu || grant_imm;
            if (grant_alu) begin
                wb_rd      <= alu_rd;
                wb_data    <= alu_data;
                mux_sel    <= GRANT_ALU;
                last_grant <= GRANT_ALU;
            end else if (grant_imm) begin
                wb_rd      <= imm_rd;
                wb_data    <= {4'b0000, imm_data};
                mux_sel    <= GRANT_IMM;
                last_grant <= GRANT_IMM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= 16'd0;
        end else if (wb_en && wb_ready) begin
            wb_count <= wb_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: table of single-cycle vectors plus hand-written
// contention, backpressure, wrap and mid-operation reset sequences.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [15:0] alu_data;
    logic [3:0]  alu_rd;
    logic        alu_ready;
    logic        imm_valid;
    logic [11:0] imm_data;
    logic [3:0]  imm_rd;
    logic        imm_ready;
    logic        wb_ready;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        mux_sel;
    logic [15:0] wb_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        alu_valid;
        logic [15:0] alu_data;
        logic [3:0]  alu_rd;
        logic        imm_valid;
        logic [11:0] imm_data;
        logic [3:0]  imm_rd;
        logic        wb_ready;
        logic        exp_alu_ready;
        logic        exp_imm_ready;
        logic        exp_wb_en;
        logic [3:0]  exp_wb_rd;
        logic [15:0] exp_wb_data;
        logic        exp_mux_sel;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [10];

    wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_data  (alu_data),
        .alu_rd    (alu_rd),
        .alu_ready (alu_ready),
        .imm_valid (imm_valid),
        .imm_data  (imm_data),
        .imm_rd    (imm_rd),
        .imm_ready (imm_ready),
        .wb_ready  (wb_ready),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .mux_sel   (mux_sel),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check_output(name, {15'd0, act}, {15'd0, exp});
    endtask

    task automatic apply_stimulus(input logic av, input logic [15:0] ad, input logic [3:0] ar,
                                  input logic iv, input logic [11:0] id, input logic [3:0] ir,
                                  input logic rdy);
        alu_valid = av;
        alu_data  = ad;
        alu_rd    = ar;
        imm_valid = iv;
        imm_data  = id;
        imm_rd    = ir;
        wb_ready  = rdy;
    endtask

    // Drive one vector, check readys mid-cycle, then check registered outputs after the edge.
    task automatic run_vector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        apply_stimulus(v.alu_valid, v.alu_data, v.alu_rd, v.imm_valid, v.imm_data, v.imm_rd, v.wb_ready);
        #1;
        check_bit({tag, " alu_ready"}, alu_ready, v.exp_alu_ready);
        check_bit({tag, " imm_ready"}, imm_ready, v.exp_imm_ready);
        @(posedge clk);
        #1;
        check_bit({tag, " wb_en"}, wb_en, v.exp_wb_en);
        if (v.exp_wb_en) begin
            check_output({tag, " wb_rd"}, {12'd0, wb_rd}, {12'd0, v.exp_wb_rd});
            check_output({tag, " wb_data"}, wb_data, v.exp_wb_data);
            check_bit({tag, " mux_sel"}, mux_sel, v.exp_mux_sel);
        end
        check_output({tag, " wb_count"}, wb_count, v.exp_count);
    endtask

    initial begin
        logic [3:0] imm_seq;
        logic       bp_imm;

`ifdef WB_ARB_RR_EN
        imm_seq = 4'b1010;
        bp_imm  = 1'b1;
`else
        imm_seq = 4'b0000;
        bp_imm  = 1'b0;
`endif

        //            av  adata     ard   iv  idata    ird   rdy  aR  iR  en  rd     data      mux  count
        vecs[0] = '{1'b1, 16'hBEEF, 4'd3, 1'b0, 12'h000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  16'hBEEF, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 16'h0000, 4'd0, 1'b0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'd1};
        vecs[2] = '{1'b0, 16'h0000, 4'd0, 1'b1, 12'hABC, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7,  16'h0ABC, 1'b1, 16'd1};
        vecs[3] = '{1'b1, 16'h1234, 4'd5, 1'b0, 12'h000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  16'h1234, 1'b0, 16'd2};
        vecs[4] = '{1'b0, 16'h0000, 4'd0, 1'b1, 12'h055, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  16'h1234, 1'b0, 16'd2};
        vecs[5] = '{1'b0, 16'h0000, 4'd0, 1'b1, 12'h055, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  16'h0055, 1'b1, 16'd3};
        vecs[6] = '{1'b0, 16'h0000, 4'd0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2,  16'h0055, 1'b1, 16'd3};
        vecs[7] = '{1'b0, 16'h0000, 4'd0, 1'b0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'd4};
        vecs[8] = '{1'b0, 16'h0000, 4'd0, 1'b1, 12'hFFF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF,  16'h0FFF, 1'b1, 16'd4};
        vecs[9] = '{1'b0, 16'h0000, 4'd0, 1'b0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 16'd5};

        // Reset state, with both lanes requesting to show readys are held low.
        rst_n = 1'b0;
        apply_stimulus(1'b1, 16'hFFFF, 4'hF, 1'b1, 12'hFFF, 4'hF, 1'b1);
        #2;
        check_bit("reset wb_en", wb_en, 1'b0);
        check_output("reset wb_rd", {12'd0, wb_rd}, 16'd0);
        check_output("reset wb_data", wb_data, 16'd0);
        check_bit("reset mux_sel", mux_sel, 1'b0);
        check_output("reset wb_count", wb_count, 16'd0);
        check_bit("reset alu_ready", alu_ready, 1'b0);
        check_bit("reset imm_ready", imm_ready, 1'b0);
        apply_stimulus(1'b0, 16'd0, 4'd0, 1'b0, 12'd0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vector(i, vecs[i]);
        end

        $display("[TB] contention sequence");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 16'h1111, 4'd1, 1'b1, 12'h222, 4'd2, 1'b1);
            #1;
            check_bit($sformatf("contend%0d alu_ready", i), alu_ready, !imm_seq[i]);
            check_bit($sformatf("contend%0d imm_ready", i), imm_ready, imm_seq[i]);
            @(posedge clk);
            #1;
            check_bit($sformatf("contend%0d mux_sel", i), mux_sel, imm_seq[i]);
            check_output($sformatf("contend%0d wb_data", i), wb_data, imm_seq[i] ? 16'h0222 : 16'h1111);
            check_output($sformatf("contend%0d wb_count", i), wb_count, 16'(5 + i));
        end

        $display("[TB] backpressure sequence");
        apply_stimulus(1'b1, 16'h1234, 4'd4, 1'b0, 12'h000, 4'd0, 1'b1);
        #1;
        check_bit("bp load alu_ready", alu_ready, 1'b1);
        @(posedge clk);
        #1;
        check_output("bp load wb_data", wb_data, 16'h1234);
        check_output("bp load wb_count", wb_count, 16'd9);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 16'h5555, 4'd6, 1'b1, 12'h333, 4'd8, 1'b0);
            #1;
            check_bit($sformatf("bp%0d alu_ready", i), alu_ready, 1'b0);
            check_bit($sformatf("bp%0d imm_ready", i), imm_ready, 1'b0);
            @(posedge clk);
            #1;
            check_bit($sformatf("bp%0d wb_en", i), wb_en, 1'b1);
            check_output($sformatf("bp%0d wb_rd", i), {12'd0, wb_rd}, 16'd4);
            check_output($sformatf("bp%0d wb_data", i), wb_data, 16'h1234);
            check_bit($sformatf("bp%0d mux_sel", i), mux_sel, 1'b0);
            check_output($sformatf("bp%0d wb_count", i), wb_count, 16'd9);
        end
        wb_ready = 1'b1;
        #1;
        check_bit("bp release alu_ready", alu_ready, !bp_imm);
        check_bit("bp release imm_ready", imm_ready, bp_imm);
        @(posedge clk);
        #1;
        check_output("bp release wb_count", wb_count, 16'd10);
        check_bit("bp release mux_sel", mux_sel, bp_imm);
        check_output("bp release wb_data", wb_data, bp_imm ? 16'h0333 : 16'h5555);
        check_output("bp release wb_rd", {12'd0, wb_rd}, bp_imm ? 16'd8 : 16'd6);

        $display("[TB] wrap sequence");
        apply_stimulus(1'b1, 16'h00AA, 4'd9, 1'b0, 12'h000, 4'd0, 1'b1);
        repeat (65525) @(posedge clk);
        #1;
        check_output("wrap max wb_count", wb_count, 16'hFFFF);
        @(posedge clk);
        #1;
        check_output("wrap zero wb_count", wb_count, 16'h0000);
        check_bit("wrap wb_en", wb_en, 1'b1);

        $display("[TB] mid-operation reset");
        wb_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("midreset wb_en", wb_en, 1'b0);
        check_output("midreset wb_count", wb_count, 16'd0);
        check_output("midreset wb_data", wb_data, 16'd0);
        check_output("midreset wb_rd", {12'd0, wb_rd}, 16'd0);
        check_bit("midreset alu_ready", alu_ready, 1'b0);
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("midreset hold wb_count", wb_count, 16'd0);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 16'h7777, 4'd1, 1'b1, 12'h444, 4'd2, 1'b1);
        #1;
        check_bit("post reset alu_ready", alu_ready, 1'b1);
        check_bit("post reset imm_ready", imm_ready, 1'b0);
        @(posedge clk);
        #1;
        check_bit("post reset wb_en", wb_en, 1'b1);
        check_output("post reset wb_data", wb_data, 16'h7777);
        check_output("post reset wb_count", wb_count, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 The ALU-lane ports SHALL be:
- alu_valid  input  1  ALU result offered.
- alu_data  input  16  ALU result.
- alu_rd  input  4  ALU destination register.
- alu_ready  output  1  ALU result accepted this cycle.
REQ-003 The immediate-lane ports SHALL be:
- imm_valid  input  1  immediate offered.
- imm_data  input  12  immediate value.
- imm_rd  input  4  immediate destination register.
- imm_ready  output  1  immediate accepted this cycle.
REQ-004 The writeback-port ports SHALL be:
- wb_ready  input  1  register-file write port consumes wb this cycle.
- wb_en  output  1  writeback valid.
- wb_rd  output  4  writeback destination.
- wb_data  output  16  writeback value.
- mux_sel  output  1  writeback source select: 0 = ALU, 1 = immediate.
- wb_count  output  16  count of completed writebacks.

Function
REQ-005 The block SHALL share the single register-file write port between the ALU lane and the immediate lane through one output register stage.
REQ-006 load = !wb_en || wb_ready; the output register SHALL accept a new entry only in a cycle where load = 1.
REQ-007 Grant rule: when load = 1 and exactly one lane is valid, that lane SHALL be granted; when neither lane is valid, no lane SHALL be granted.
REQ-008 Ready outputs:
- alu_ready = load && grant == ALU.
- imm_ready = load && grant == IMM.
- Each ready is combinational from the valids, wb_en and wb_ready.
- At most one ready SHALL be high per cycle.
REQ-009 A lane's transfer SHALL occur exactly in a cycle where its valid and ready are both 1.
REQ-010 On an ALU transfer, the next cycle SHALL show wb_en = 1, wb_rd = alu_rd, wb_data = alu_data and mux_sel = 0.
REQ-011 On an IMM transfer, the next cycle SHALL show wb_en = 1, wb_rd = imm_rd, wb_data = {4'b0000, imm_data} (zero-extended) and mux_sel = 1.
REQ-012 Latency from transfer to wb_en SHALL be 1 cycle; back-to-back transfers SHALL sustain 1 writeback per cycle while wb_ready = 1.
REQ-013 While wb_en = 1 and wb_ready = 0, wb_en, wb_rd, wb_data and mux_sel SHALL hold stable and both readys SHALL be 0.
REQ-014 When wb_en = 1, wb_ready = 1 and no lane transfers, wb_en SHALL go to 0 on the next cycle.
REQ-015 A last_grant state bit (ALU/IMM) SHALL update to the granted lane on every transfer and hold otherwise.
REQ-016 Both lanes valid with load = 1 SHALL be resolved by the compile-time policy in REQ-022 and REQ-023.
REQ-017 wb_count SHALL increment by 1 on each cycle with wb_en && wb_ready.
REQ-018 wb_count SHALL wrap from 0xFFFF to 0x0000.
REQ-019 Ordering between lanes SHALL follow transfer order only; same-destination hazards are the requesters' responsibility.

Reset
REQ-020 On rst_n = 0, asynchronously:
- wb_en = 0, wb_rd = 0, wb_data = 0, mux_sel = 0.
- wb_count = 0.
- last_grant = IMM.
- Readys SHALL be 0 while rst_n = 0.
REQ-021 Reset asserted mid-operation SHALL discard any pending writeback without completing it; wb_count SHALL not increment for the discarded entry.

Configuration
REQ-022 With WB_ARB_RR_EN defined, when both lanes are valid the lane other than last_grant SHALL be granted (round-robin); the first contention after reset SHALL grant ALU.
REQ-023 Without WB_ARB_RR_EN, the ALU lane SHALL always win contention (fixed priority); last_grant SHALL still be maintained but SHALL not affect the grant.

Verification
REQ-024 ALU transfer: reset release, alu_valid = 1, alu_data = 0xBEEF, alu_rd = 3, wb_ready = 1 -> alu_ready = 1 the same cycle; next cycle wb_en = 1, wb_rd = 3, wb_data = 0xBEEF, mux_sel = 0; wb_count = 1 one cycle later.
REQ-025 IMM zero-extend: imm_valid = 1, imm_data = 0xABC, imm_rd = 7 -> next cycle wb_data = 0x0ABC, wb_rd = 7, mux_sel = 1.
REQ-026 Round-robin contention (WB_ARB_RR_EN): both lanes valid for 4 cycles, wb_ready = 1 -> grants ALU, IMM, ALU, IMM and mux_sel sequence 0,1,0,1.
REQ-027 Fixed-priority contention (no macro): same stimulus as REQ-026 -> 4 ALU grants, imm_ready stays 0.
REQ-028 Backpressure: wb_en = 1 holding 0x1234, wb_ready = 0 for 3 cycles with both lanes valid -> outputs stable, readys 0, wb_count unchanged; wb_ready = 1 -> wb_count +1 and the next grant is loaded the same cycle.
REQ-029 Wrap and reset: preload 65535 writebacks, one more -> wb_count = 0x0000; assert rst_n = 0 while wb_en = 1 and wb_ready = 0 -> wb_en = 0 immediately and wb_count = 0.
